// File: rtl/sram_dp_arbiter.sv
// Round-robin arbiter mapping up to two of N requesters per cycle onto the
// two ports of a dual-port synchronous SRAM. After reset it walks the whole
// memory writing zeros (two locations per cycle) before serving requests.
// Read data comes back one cycle after the SRAM output, as a registered
// rvalid/rdata pulse on the lane of the requester that issued the read.
module sram_dp_arbiter #(
    parameter int N  = 4,
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      req_we,
    input  logic [N*AW-1:0]   req_addr,
    input  logic [N*DW-1:0]   req_wdata,
    output logic [N-1:0]      gnt,
    output logic [N-1:0]      rvalid,
    output logic [N*DW-1:0]   rdata,
    output logic              init_done,
    output logic [AW-1:0]     addr_a,
    output logic [AW-1:0]     addr_b,
    output logic [DW-1:0]     data_a,
    output logic [DW-1:0]     data_b,
    output logic              we_a,
    output logic              we_b,
    input  logic [DW-1:0]     q_a,
    input  logic [DW-1:0]     q_b
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = AW - 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] clr_cnt;
    logic [IW-1:0] rr_ptr;

    logic [AW-1:0] addr_arr  [N];
    logic [DW-1:0] wdata_arr [N];

    logic          a_found;
    logic          b_found;
    logic [IW-1:0] a_idx;
    logic [IW-1:0] b_idx;
    logic          a_rd;
    logic          b_rd;

    logic          tag_a_vld;
    logic          tag_b_vld;
    logic [IW-1:0] tag_a_idx;
    logic [IW-1:0] tag_b_idx;

    // Pointer to the requester just after idx, wrapping at N.
    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] idx);
        if (int'(idx) == N - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Unpack the flattened per-requester address and write-data buses.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            addr_arr[i]  = req_addr[i*AW +: AW];
            wdata_arr[i] = req_wdata[i*DW +: DW];
        end
    end

    // Circular scan from rr_ptr: first requester takes port A, the next
    // compatible one takes port B (a same-address pair is only allowed if
    // both are reads).
    always_comb begin
        int            cand;
        logic [IW-1:0] cidx;
        cand    = 0;
        cidx    = '0;
        a_found = 1'b0;
        b_found = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        for (int off = 0; off < N; off++) begin
            cand = int'(rr_ptr) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            cidx = cand[IW-1:0];
            if (req[cidx]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = cidx;
                end else if (!b_found &&
                             !((addr_arr[cidx] == addr_arr[a_idx]) &&
                               (req_we[cidx] || req_we[a_idx]))) begin
                    b_found = 1'b1;
                    b_idx   = cidx;
                end
            end
        end
    end

    // Next state: leave INIT once the last address pair has been cleared.
    always_comb begin
        state_next = state;
        if ((state == ST_INIT) && (clr_cnt == '1)) begin
            state_next = ST_RUN;
        end
    end

    // Port and grant drive: clear pattern during INIT, winners during RUN,
    // everything quiet while reset is asserted.
    always_comb begin
        gnt    = '0;
        we_a   = 1'b0;
        we_b   = 1'b0;
        addr_a = '0;
        addr_b = '0;
        data_a = '0;
        data_b = '0;
        if (rst_n) begin
            if (state == ST_INIT) begin
                we_a   = 1'b1;
                we_b   = 1'b1;
                addr_a = {clr_cnt, 1'b0};
                addr_b = {clr_cnt, 1'b1};
            end else begin
                if (a_found) begin
                    gnt[a_idx] = 1'b1;
                    we_a       = req_we[a_idx];
                    addr_a     = addr_arr[a_idx];
                    data_a     = wdata_arr[a_idx];
                end
                if (b_found) begin
                    gnt[b_idx] = 1'b1;
                    we_b       = req_we[b_idx];
                    addr_b     = addr_arr[b_idx];
                    data_b     = wdata_arr[b_idx];
                end
            end
        end
    end

    assign a_rd = (state == ST_RUN) && a_found && !req_we[a_idx];
    assign b_rd = (state == ST_RUN) && b_found && !req_we[b_idx];

    // State register, clear counter and init_done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (state_next == ST_RUN) begin
                init_done <= 1'b1;
            end
        end
    end

    // Round-robin pointer moves past the last requester granted this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if ((state == ST_RUN) && a_found) begin
            rr_ptr <= next_ptr(b_found ? b_idx : a_idx);
        end
    end

    // Remember which requester owns each port's read while the SRAM fetches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_a_vld <= 1'b0;
            tag_b_vld <= 1'b0;
            tag_a_idx <= '0;
            tag_b_idx <= '0;
        end else begin
            tag_a_vld <= a_rd;
            tag_b_vld <= b_rd;
            tag_a_idx <= a_idx;
            tag_b_idx <= b_idx;
        end
    end

    // Capture SRAM output into the owning requester's lane as a 1-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= '0;
            if (tag_a_vld) begin
                rvalid[tag_a_idx]                  <= 1'b1;
                rdata[int'(tag_a_idx)*DW +: DW]    <= q_a;
            end
            if (tag_b_vld) begin
                rvalid[tag_b_idx]                  <= 1'b1;
                rdata[int'(tag_b_idx)*DW +: DW]    <= q_b;
            end
        end
    end

endmodule

// File: tb/tb_sram_dp_arbiter.sv
// Bench for sram_dp_arbiter: a dual-port SRAM model, a queue-based reference
// of the arbitration rules checked every negedge, and directed scenarios
// with hand-computed expectations.
module tb_sram_dp_arbiter;

    localparam int N    = 4;
    localparam int AW   = 6;
    localparam int DW   = 8;
    localparam int NCLR = 32;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [N*DW-1:0] rdata;
    logic            init_done;
    logic [AW-1:0]   addr_a;
    logic [AW-1:0]   addr_b;
    logic [DW-1:0]   data_a;
    logic [DW-1:0]   data_b;
    logic            we_a;
    logic            we_b;
    logic [DW-1:0]   q_a = '0;
    logic [DW-1:0]   q_b = '0;

    logic [DW-1:0]   sram [64] = '{default: 8'hEE};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_dp_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .init_done (init_done),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .we_a      (we_a),
        .we_b      (we_b),
        .q_a       (q_a),
        .q_b       (q_b)
    );

    // Synchronous dual-port SRAM with registered read data.
    always @(posedge clk) begin
        if (we_a) sram[addr_a] <= data_a;
        if (we_b) sram[addr_b] <= data_b;
        q_a <= sram[addr_a];
        q_b <= sram[addr_b];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rd(input int i);
        return rdata[i*DW +: DW];
    endfunction

    // ---------------- reference model ----------------
    int              m_clr;
    int              m_rr;
    logic [DW-1:0]   m_mem [64] = '{default: 8'hEE};
    logic [N-1:0]    s1_v, s2_v;
    logic [DW-1:0]   s1_d [N];
    logic [DW-1:0]   s2_d [N];
    logic [DW-1:0]   m_rdata [N];
    logic [N-1:0]    n_v;
    logic [DW-1:0]   n_d [N];
    int              order [$];
    int              wa, wb;
    logic [N-1:0]    e_gnt, e_rv;
    logic            e_wea, e_web, e_done;
    logic [AW-1:0]   e_aa, e_ab;
    logic [DW-1:0]   e_da, e_db;
    logic [N*DW-1:0] e_rdata;

    // Predict every output from the arbitration rules and compare each cycle.
    always @(negedge clk) begin
        e_gnt = '0; e_rv = '0; e_wea = 1'b0; e_web = 1'b0; e_done = 1'b0;
        e_aa = '0; e_ab = '0; e_da = '0; e_db = '0;
        n_v = '0; wa = -1; wb = -1;
        for (int i = 0; i < N; i++) n_d[i] = '0;
        if (!rst_n) begin
            m_clr = 0; m_rr = 0; s1_v = '0; s2_v = '0;
            for (int i = 0; i < N; i++) m_rdata[i] = '0;
        end else begin
            e_rv = s2_v;
            for (int i = 0; i < N; i++) if (s2_v[i]) m_rdata[i] = s2_d[i];
            e_done = (m_clr == NCLR);
            if (m_clr < NCLR) begin
                e_wea = 1'b1; e_web = 1'b1;
                e_aa = AW'(2*m_clr); e_ab = AW'(2*m_clr + 1);
                m_mem[2*m_clr] = '0; m_mem[2*m_clr + 1] = '0;
                m_clr++;
            end else begin
                order.delete();
                for (int j = 0; j < N; j++)
                    if (req[(m_rr + j) % N]) order.push_back((m_rr + j) % N);
                if (order.size() > 0) wa = order[0];
                for (int j = 1; j < order.size(); j++)
                    if (wb < 0 && !(req_addr[order[j]*AW +: AW] == req_addr[wa*AW +: AW]
                                    && (req_we[order[j]] || req_we[wa])))
                        wb = order[j];
                if (wa >= 0) begin
                    e_gnt[wa] = 1'b1; e_wea = req_we[wa];
                    e_aa = req_addr[wa*AW +: AW]; e_da = req_wdata[wa*DW +: DW];
                    if (!e_wea) begin n_v[wa] = 1'b1; n_d[wa] = m_mem[e_aa]; end
                end
                if (wb >= 0) begin
                    e_gnt[wb] = 1'b1; e_web = req_we[wb];
                    e_ab = req_addr[wb*AW +: AW]; e_db = req_wdata[wb*DW +: DW];
                    if (!e_web) begin n_v[wb] = 1'b1; n_d[wb] = m_mem[e_ab]; end
                end
                if (wa >= 0 && e_wea) m_mem[e_aa] = e_da;
                if (wb >= 0 && e_web) m_mem[e_ab] = e_db;
                if (wa >= 0) m_rr = ((wb >= 0 ? wb : wa) + 1) % N;
            end
        end
        for (int i = 0; i < N; i++) e_rdata[i*DW +: DW] = m_rdata[i];
        check("model gnt", gnt, e_gnt);
        check("model we_a", we_a, e_wea);
        check("model we_b", we_b, e_web);
        check("model addr_a", addr_a, e_aa);
        check("model addr_b", addr_b, e_ab);
        if (e_wea || wa < 0) check("model data_a", data_a, e_da);
        if (e_web || wb < 0) check("model data_b", data_b, e_db);
        check("model rvalid", rvalid, e_rv);
        check("model rdata", rdata, e_rdata);
        check("model init_done", init_done, e_done);
        if (rst_n) begin
            s2_v = s1_v; s2_d = s1_d; s1_v = n_v; s1_d = n_d;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_r(input int i, input logic we, input int addr, input logic [DW-1:0] d);
        req[i]                = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = AW'(addr);
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clr_req();
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int gcnt [N];

    initial begin
        clr_req();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset gnt", gnt, 4'b0000);
        check("reset we_a", we_a, 1'b0);
        check("reset init_done", init_done, 1'b0);
        check("reset rvalid", rvalid, 4'b0000);
        step();
        rst_n = 1'b1;
        set_r(3, 1'b0, 0, 8'h00);             // held through INIT, must wait
        for (int k = 0; k < NCLR; k++) begin
            @(negedge clk);
            check("init gnt", gnt, 4'b0000);
            if (k == 0) begin
                check("init first addr_a", addr_a, 0);
                check("init first addr_b", addr_b, 1);
                check("init first we_b", we_b, 1'b1);
            end
            if (k == NCLR - 1) begin
                check("init last addr_a", addr_a, 62);
                check("init last addr_b", addr_b, 63);
                check("init last init_done", init_done, 1'b0);
            end
            step();
        end
        // first RUN cycle: R3 read addr 0
        @(negedge clk);
        check("run init_done", init_done, 1'b1);
        check("held req gnt", gnt, 4'b1000);
        step(); clr_req(); set_r(2, 1'b0, 17, 8'h00); set_r(3, 1'b0, 63, 8'h00);
        @(negedge clk);
        check("read 17/63 gnt", gnt, 4'b1100);
        step(); clr_req();
        @(negedge clk);
        check("addr0 rvalid", rvalid, 4'b1000);
        check("addr0 rdata", rd(3), 8'h00);
        step();
        @(negedge clk);
        check("addr17/63 rvalid", rvalid, 4'b1100);
        check("addr17 rdata", rd(2), 8'h00);
        check("addr63 rdata", rd(3), 8'h00);
        // write 5A@5 with read 9, then read 5
        step(); set_r(0, 1'b1, 5, 8'h5A); set_r(1, 1'b0, 9, 8'h00);
        @(negedge clk);
        check("wr/rd gnt", gnt, 4'b0011);
        check("wr we_a", we_a, 1'b1);
        check("wr addr_a", addr_a, 5);
        check("wr data_a", data_a, 8'h5A);
        check("rd addr_b", addr_b, 9);
        step(); clr_req(); set_r(0, 1'b0, 5, 8'h00);
        @(negedge clk);
        check("rd5 gnt", gnt, 4'b0001);
        step(); clr_req();
        @(negedge clk);
        check("rd9 rvalid", rvalid, 4'b0010);
        check("rd9 rdata", rd(1), 8'h00);
        step();
        @(negedge clk);
        check("rd5 rvalid", rvalid, 4'b0001);
        check("rd5 rdata", rd(0), 8'h5A);
        // move rr_ptr back to 0
        step(); set_r(3, 1'b1, 50, 8'h11);
        @(negedge clk);
        check("r3 wr gnt", gnt, 4'b1000);
        // collision: R0 writes 33@12, R1 reads 12
        step(); clr_req(); set_r(0, 1'b1, 12, 8'h33); set_r(1, 1'b0, 12, 8'h00);
        @(negedge clk);
        check("collision gnt", gnt, 4'b0001);
        check("collision we_b", we_b, 1'b0);
        step(); clr_req(); set_r(1, 1'b0, 12, 8'h00);
        @(negedge clk);
        check("deferred gnt", gnt, 4'b0010);
        step(); clr_req();
        @(negedge clk);
        step();
        @(negedge clk);
        check("deferred rvalid", rvalid, 4'b0010);
        check("deferred rdata", rd(1), 8'h33);
        // same-address dual read
        step(); set_r(0, 1'b1, 40, 8'hC3);
        @(negedge clk);
        check("wr40 gnt", gnt, 4'b0001);
        step(); clr_req(); set_r(2, 1'b0, 40, 8'h00); set_r(3, 1'b0, 40, 8'h00);
        @(negedge clk);
        check("dual rd gnt", gnt, 4'b1100);
        check("dual rd addr_b", addr_b, 40);
        step(); clr_req();
        @(negedge clk);
        step();
        @(negedge clk);
        check("dual rd rvalid", rvalid, 4'b1100);
        check("dual rd rdata2", rd(2), 8'hC3);
        check("dual rd rdata3", rd(3), 8'hC3);
        // fairness: everyone reading continuously for 8 cycles
        step();
        set_r(0, 1'b0, 0, 8'h00); set_r(1, 1'b0, 17, 8'h00);
        set_r(2, 1'b0, 40, 8'h00); set_r(3, 1'b0, 63, 8'h00);
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("fair gnt", gnt, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            for (int i = 0; i < N; i++) if (gnt[i]) gcnt[i]++;
            step();
        end
        clr_req();
        for (int i = 0; i < N; i++) check("fair count", gcnt[i], 4);
        @(negedge clk); step();
        @(negedge clk); step();
        // async reset with reads in flight
        set_r(0, 1'b0, 5, 8'h00); set_r(1, 1'b0, 9, 8'h00);
        @(negedge clk);
        check("pre-reset gnt", gnt, 4'b0011);
        step();
        rst_n = 1'b0;
        #1;
        check("async gnt", gnt, 4'b0000);
        check("async we_a", we_a, 1'b0);
        check("async init_done", init_done, 1'b0);
        @(negedge clk);
        check("async rvalid", rvalid, 4'b0000);
        check("async we_b", we_b, 1'b0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < NCLR; k++) begin
            @(negedge clk);
            check("reinit init_done", init_done, 1'b0);
            check("reinit rvalid", rvalid, 4'b0000);
            step();
        end
        @(negedge clk);
        check("post-reset gnt", gnt, 4'b0011);
        check("post-reset init_done", init_done, 1'b1);
        step(); clr_req();
        @(negedge clk);
        step();
        @(negedge clk);
        check("recleared rvalid", rvalid, 4'b0011);
        check("recleared rdata", rd(0), 8'h00);
        step();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
